// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// Optional macro ALU_ARB_ZERO_EN adds per-port result-is-zero flags.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_op,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_op,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_data,
  output logic              rsp1_err,
`ifdef ALU_ARB_ZERO_EN
  output logic              rsp0_zero,
  output logic              rsp1_zero,
`endif
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_contr,
  input  logic [WIDTH-1:0]  alu_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             prio;
  logic             owner;
  logic             win;
  logic             grant;
  logic             op_legal;
  logic [WIDTH-1:0] result;

  // Grant winner: lone requester wins, otherwise the port holding priority.
  always_comb begin
    win        = (req0_valid && req1_valid) ? prio : req1_valid;
    grant      = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = grant && !win;
    req1_ready = grant && win;
  end

  always_comb begin
    op_legal = alu_contr inside {CTRL_W'(4'b0000), CTRL_W'(4'b0001), CTRL_W'(4'b0010),
                                 CTRL_W'(4'b0110), CTRL_W'(4'b0111), CTRL_W'(4'b1100)};
    result   = op_legal ? alu_out : '0;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_contr  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_err   <= 1'b0;
`ifdef ALU_ARB_ZERO_EN
      rsp0_zero  <= 1'b0;
      rsp1_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            alu_contr <= win ? req1_op : req0_op;
            alu_a     <= win ? req1_a  : req0_a;
            alu_b     <= win ? req1_b  : req0_b;
            owner     <= win;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // Only the owner's response registers change; the other port keeps its last result.
          if (owner) begin
            rsp1_data  <= result;
            rsp1_err   <= !op_legal;
            rsp1_valid <= 1'b1;
`ifdef ALU_ARB_ZERO_EN
            rsp1_zero  <= (result == '0);
`endif
          end else begin
            rsp0_data  <= result;
            rsp0_err   <= !op_legal;
            rsp0_valid <= 1'b1;
`ifdef ALU_ARB_ZERO_EN
            rsp0_zero  <= (result == '0);
`endif
          end
          state <= RESP;
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            prio       <= ~owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level reference model
// Zero-flag checks are compiled in when ALU_ARB_ZERO_EN is defined.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [C-1:0] req0_op, req1_op, alu_contr;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp0_err, rsp1_err;
  logic [W-1:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_out;
  logic         busy;
`ifdef ALU_ARB_ZERO_EN
  logic         rsp0_zero, rsp1_zero;
`endif

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         prio_m;
  logic [W-1:0] exp_data [2];
  logic         exp_err  [2];
  logic         exp_zero [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.WIDTH(W), .CTRL_W(C)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
`ifdef ALU_ARB_ZERO_EN
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_contr(alu_contr), .alu_out(alu_out), .busy(busy)
  );

  // External ALU; illegal codes yield junk so the arbiter must zero them itself.
  function automatic logic [W-1:0] alu_model(input logic [C-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic bit is_legal(input logic [C-1:0] op);
    return op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd6 || op == 4'd7 || op == 4'd12;
  endfunction

  always_comb alu_out = alu_model(alu_contr, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [C-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (p == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic check_reset_state;
    check("rst_busy", busy, 0);
    check("rst_v0", rsp0_valid, 0);
    check("rst_v1", rsp1_valid, 0);
    check("rst_d0", rsp0_data, 0);
    check("rst_d1", rsp1_data, 0);
    check("rst_e0", rsp0_err, 0);
    check("rst_e1", rsp1_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_c", alu_contr, 0);
`ifdef ALU_ARB_ZERO_EN
    check("rst_z0", rsp0_zero, 0);
    check("rst_z1", rsp1_zero, 0);
`endif
  endtask

  task automatic model_reset;
    prio_m = 1'b0;
    for (int i = 0; i < 2; i++) begin exp_data[i] = '0; exp_err[i] = 1'b0; exp_zero[i] = 1'b0; end
  endtask

  task automatic check_rsp(input logic ew);
    check("rsp_busy", busy, 1);
    check("rsp_v0", rsp0_valid, !ew);
    check("rsp_v1", rsp1_valid, ew);
    check("rsp_d0", rsp0_data, exp_data[0]);
    check("rsp_d1", rsp1_data, exp_data[1]);
    check("rsp_e0", rsp0_err, exp_err[0]);
    check("rsp_e1", rsp1_err, exp_err[1]);
`ifdef ALU_ARB_ZERO_EN
    check("rsp_z0", rsp0_zero, exp_zero[0]);
    check("rsp_z1", rsp1_zero, exp_zero[1]);
`endif
  endtask

  // One full transaction starting in an idle cycle; the caller has set up the request inputs.
  task automatic serve(input int rdelay, input bit raise_other, output int gcyc);
    logic         ew;
    logic [C-1:0] op;
    logic [W-1:0] a, b, r;
    bit           legal;
    #1;
    ew = (req0_valid && req1_valid) ? prio_m : req1_valid;
    check("req0_ready", req0_ready, req0_valid && !ew);
    check("req1_ready", req1_ready, req1_valid && ew);
    op    = ew ? req1_op : req0_op;
    a     = ew ? req1_a  : req0_a;
    b     = ew ? req1_b  : req0_b;
    legal = is_legal(op);
    r     = legal ? alu_model(op, a, b) : '0;
    tick;
    gcyc = cyc;
    // Operands change after acceptance; the captured values must be used.
    if (ew) begin req1_valid = 0; req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom); end
    else    begin req0_valid = 0; req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom); end
    if (raise_other) begin if (ew) req0_valid = 1; else req1_valid = 1; end
    #1;
    check("exec_busy", busy, 1);
    check("exec_ready0", req0_ready, 0);
    check("exec_ready1", req1_ready, 0);
    check("exec_v0", rsp0_valid, 0);
    check("exec_v1", rsp1_valid, 0);
    check("exec_alu_c", alu_contr, op);
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    exp_data[ew] = r;
    exp_err[ew]  = !legal;
    exp_zero[ew] = (r == '0);
    if (ew) rsp0_ready = 1; else rsp1_ready = 1;
    tick;
    check_rsp(ew);
    repeat (rdelay) begin
      tick;
      check_rsp(ew);
      check("hold_ready0", req0_ready, 0);
      check("hold_ready1", req1_ready, 0);
    end
    if (ew) rsp1_ready = 1; else rsp0_ready = 1;
    tick;
    rsp0_ready = 0;
    rsp1_ready = 0;
    check("done_v0", rsp0_valid, 0);
    check("done_v1", rsp1_valid, 0);
    check("done_busy", busy, 0);
    prio_m = ~ew;
  endtask

  logic [C-1:0] ops [8];
  int           g, prev;

  initial begin
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
    reset_n = 0; rsp0_ready = 0; rsp1_ready = 0;
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    model_reset();
    tick; tick;
    check_reset_state();
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    reset_n = 1;

    // ADD on port 0
    set_req(0, 1, 4'b0010, 32'd5, 32'd7);
    serve(0, 0, g);
    check("add_data", rsp0_data, 32'd12);

    // Both ports valid at reset exit
    reset_n = 0;
    set_req(0, 1, 4'b0110, 32'd10, 32'd3);
    set_req(1, 1, 4'b0001, 32'hF0, 32'h0F);
    tick;
    model_reset();
    reset_n = 1;
    serve(0, 0, g);
    check("sub_data", rsp0_data, 32'd7);
    serve(0, 0, g);
    check("or_data", rsp1_data, 32'hFF);
    set_req(0, 1, 4'b0010, 32'd1, 32'd1);
    set_req(1, 1, 4'b0010, 32'd2, 32'd2);
    #1;
    check("prio_end0", req0_ready, 1);
    check("prio_end1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // SLT on port 1 with a stalled consumer; port 0 arrives mid-flight
    set_req(1, 1, 4'b0111, 32'd2, 32'd9);
    set_req(0, 0, 4'b0010, 32'd100, 32'd1);
    serve(5, 1, g);
    check("slt_data", rsp1_data, 32'd1);
    serve(0, 0, g);

    // Illegal opcode
    set_req(0, 1, 4'b0011, 32'h1234, 32'h5678);
    serve(1, 0, g);
    check("ill_data", rsp0_data, 32'd0);
    check("ill_err", rsp0_err, 1);
`ifdef ALU_ARB_ZERO_EN
    check("ill_zero", rsp0_zero, 1);
`endif

    // NOR then back-to-back port 0 operations
    set_req(0, 1, 4'b1100, 32'd0, 32'd0);
    serve(0, 0, prev);
    check("nor_data", rsp0_data, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1, 4'b0010, $urandom, $urandom);
      serve(0, 0, g);
      check("b2b_gap", g - prev, 3);
      prev = g;
    end

    // Reset during EXEC aborts the operation; priority returns to port 0
    set_req(1, 1, 4'b0010, 32'd40, 32'd2);
    #1;
    tick;
    req1_valid = 0;
    check("pre_rst_busy", busy, 1);
    reset_n = 0;
    tick;
    check_reset_state();
    reset_n = 1;
    model_reset();
    repeat (3) begin
      tick;
      check("abort_v1", rsp1_valid, 0);
      check("abort_busy", busy, 0);
    end
    set_req(0, 1, 4'b0001, 32'h3, 32'h4);
    set_req(1, 1, 4'b0000, 32'hF, 32'h5);
    serve(0, 0, g);
    serve(0, 0, g);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit v0, v1, raise;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1;
      set_req(0, v0, ops[$urandom_range(0, 7)], ($urandom % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom, $urandom);
      set_req(1, v1, ops[$urandom_range(0, 7)], $urandom, ($urandom % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      raise = !(v0 && v1) && ($urandom % 2 == 0);
      serve($urandom_range(0, 3), raise, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
